// File: rtl/mont_exp_ctrl.sv
// Left-to-right square-and-multiply modular exponentiation controller.
// Drives one external Montgomery multiplier over a start/done handshake.
module mont_exp_ctrl #(
  parameter int WIDTH   = 512,
  parameter int E_WIDTH = 512,
  parameter int LW      = 10
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [WIDTH-1:0]   in_xm,
  input  logic [WIDTH-1:0]   in_rm,
  input  logic [WIDTH-1:0]   in_m,
  input  logic [E_WIDTH-1:0] in_e,
  input  logic [LW-1:0]      in_elen,
  output logic [WIDTH-1:0]   result,
  output logic               done,
  output logic               busy,
  output logic               mm_start,
  output logic [WIDTH-1:0]   mm_a,
  output logic [WIDTH-1:0]   mm_b,
  output logic [WIDTH-1:0]   mm_m,
  input  logic [WIDTH-1:0]   mm_result,
  input  logic               mm_done
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_SQ_ISSUE  = 3'd1;
  localparam logic [2:0] S_SQ_WAIT   = 3'd2;
  localparam logic [2:0] S_MUL_ISSUE = 3'd3;
  localparam logic [2:0] S_MUL_WAIT  = 3'd4;
  localparam logic [2:0] S_OUT_ISSUE = 3'd5;
  localparam logic [2:0] S_OUT_WAIT  = 3'd6;
  localparam logic [2:0] S_DONE      = 3'd7;

  localparam logic [LW-1:0] ELEN_MAX = LW'(E_WIDTH);

  logic [2:0]         state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   xm_q, xm_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [E_WIDTH-1:0] e_q, e_d;
  logic [LW-1:0]      i_q, i_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               done_q, done_d;
  logic               mm_start_q, mm_start_d;
  logic [WIDTH-1:0]   mm_a_q, mm_a_d;
  logic [WIDTH-1:0]   mm_b_q, mm_b_d;

  logic [LW-1:0]      n_elen;
  logic [E_WIDTH-1:0] e_sh;
  logic               e_bit;

  // Shift rather than index so the counter width need not match log2(E_WIDTH).
  assign e_sh  = e_q >> i_q;
  assign e_bit = e_sh[0];
  assign n_elen = (in_elen > ELEN_MAX) ? ELEN_MAX : in_elen;

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    xm_d       = xm_q;
    m_d        = m_q;
    e_d        = e_q;
    i_d        = i_q;
    result_d   = result_q;
    done_d     = 1'b0;
    mm_start_d = 1'b0;
    mm_a_d     = mm_a_q;
    mm_b_d     = mm_b_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          xm_d    = in_xm;
          m_d     = in_m;
          e_d     = in_e;
          acc_d   = in_rm;
          i_d     = n_elen;
          state_d = (n_elen != '0) ? S_SQ_ISSUE : S_OUT_ISSUE;
        end
      end
      S_SQ_ISSUE: begin
        i_d     = i_q - LW'(1);
        state_d = S_SQ_WAIT;
      end
      S_SQ_WAIT: begin
        if (mm_done) begin
          acc_d = mm_result;
          if (e_bit)          state_d = S_MUL_ISSUE;
          else if (i_q != '0) state_d = S_SQ_ISSUE;
          else                state_d = S_OUT_ISSUE;
        end
      end
      S_MUL_ISSUE: state_d = S_MUL_WAIT;
      S_MUL_WAIT: begin
        if (mm_done) begin
          acc_d   = mm_result;
          state_d = (i_q != '0) ? S_SQ_ISSUE : S_OUT_ISSUE;
        end
      end
      S_OUT_ISSUE: state_d = S_OUT_WAIT;
      S_OUT_WAIT: begin
        if (mm_done) begin
          result_d = mm_result;
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Operands are loaded on entry to an issue state so they are already
    // registered in the cycle mm_start is high and stay put until the next issue.
    case (state_d)
      S_SQ_ISSUE: begin
        mm_start_d = 1'b1;
        mm_a_d     = acc_d;
        mm_b_d     = acc_d;
      end
      S_MUL_ISSUE: begin
        mm_start_d = 1'b1;
        mm_a_d     = acc_d;
        mm_b_d     = xm_d;
      end
      S_OUT_ISSUE: begin
        mm_start_d = 1'b1;
        mm_a_d     = acc_d;
        mm_b_d     = WIDTH'(1);
      end
      S_DONE:  done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      xm_q       <= '0;
      m_q        <= '0;
      e_q        <= '0;
      i_q        <= '0;
      result_q   <= '0;
      done_q     <= 1'b0;
      mm_start_q <= 1'b0;
      mm_a_q     <= '0;
      mm_b_q     <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      xm_q       <= xm_d;
      m_q        <= m_d;
      e_q        <= e_d;
      i_q        <= i_d;
      result_q   <= result_d;
      done_q     <= done_d;
      mm_start_q <= mm_start_d;
      mm_a_q     <= mm_a_d;
      mm_b_q     <= mm_b_d;
    end
  end

  assign result   = result_q;
  assign done     = done_q;
  assign busy     = (state_q != S_IDLE);
  assign mm_start = mm_start_q;
  assign mm_a     = mm_a_q;
  assign mm_b     = mm_b_q;
  assign mm_m     = m_q;

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Bench for mont_exp_ctrl: behavioural Montgomery multiplier, directed vector
// table, handshake corner sequences and a full-width random exponentiation.
module tb_mont_exp_ctrl;
  localparam int W  = 512;
  localparam int EW = 512;
  localparam int LW = 10;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  in_xm = '0, in_rm = '0, in_m = '0;
  logic [EW-1:0] in_e = '0;
  logic [LW-1:0] in_elen = '0;
  logic [W-1:0]  result;
  logic          done, busy, mm_start;
  logic [W-1:0]  mm_a, mm_b, mm_m;
  logic [W-1:0]  mm_result = '0;
  logic          mm_done = 1'b0;

  mont_exp_ctrl #(.WIDTH(W), .E_WIDTH(EW), .LW(LW)) dut (
    .clk(clk), .resetn(resetn), .start(start),
    .in_xm(in_xm), .in_rm(in_rm), .in_m(in_m), .in_e(in_e), .in_elen(in_elen),
    .result(result), .done(done), .busy(busy),
    .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b), .mm_m(mm_m),
    .mm_result(mm_result), .mm_done(mm_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // a*b*2^-W mod m, bit-serial; needs a,b < m
  function automatic logic [W-1:0] mont(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [W-1:0] m);
    logic [W+1:0] t;
    t = '0;
    for (int unsigned k = 0; k < W; k++) begin
      if (a[k]) t = t + {2'b00, b};
      if (t[0]) t = t + {2'b00, m};
      t = t >> 1;
    end
    if (t >= {2'b00, m}) t = t - {2'b00, m};
    return t[W-1:0];
  endfunction

  function automatic logic [W-1:0] to_mont(input logic [W-1:0] x, input logic [W-1:0] m);
    logic [2*W-1:0] t;
    t = {x, {W{1'b0}}} % {{W{1'b0}}, m};
    return t[W-1:0];
  endfunction

  function automatic logic [W-1:0] mulmod(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [W-1:0] m);
    logic [2*W-1:0] t;
    t = ({{W{1'b0}}, a} * {{W{1'b0}}, b}) % {{W{1'b0}}, m};
    return t[W-1:0];
  endfunction

  function automatic logic [W-1:0] modexp(input logic [W-1:0] x, input logic [EW-1:0] e,
                                          input int n, input logic [W-1:0] m);
    logic [W-1:0] r;
    r = W'(1) % m;
    for (int i = n - 1; i >= 0; i--) begin
      r = mulmod(r, r, m);
      if (e[i]) r = mulmod(r, x, m);
    end
    return r;
  endfunction

  function automatic logic [W-1:0] rnd_w();
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < W / 32; i++) r = {r[W-33:0], 32'($urandom)};
    return r;
  endfunction

  // ---------------- multiplier model ----------------
  int           k_mode = 1;
  int           cnt = 0;
  logic         pend = 1'b0;
  logic [W-1:0] cap_a = '0, cap_b = '0, cap_m = '0, res_q = '0;
  int           start_cnt = 0, done_cnt = 0, stab_cnt = 0;
  logic         spur_tog = 1'b0, spur_seen = 1'b0;
  logic [W-1:0] log_a[$];
  logic [W-1:0] log_b[$];

  always @(posedge clk) begin
    mm_done <= 1'b0;
    if (done) done_cnt <= done_cnt + 1;
    if (!resetn) begin
      pend <= 1'b0;
    end else begin
      if (pend) begin
        if (mm_a !== cap_a || mm_b !== cap_b || mm_m !== cap_m) stab_cnt <= stab_cnt + 1;
        if (cnt <= 1) begin
          mm_done   <= 1'b1;
          mm_result <= res_q;
          pend      <= 1'b0;
        end else begin
          cnt <= cnt - 1;
        end
      end
      if (mm_start) begin
        pend      <= 1'b1;
        cap_a     <= mm_a;
        cap_b     <= mm_b;
        cap_m     <= mm_m;
        res_q     <= mont(mm_a, mm_b, mm_m);
        cnt       <= (k_mode == 0) ? int'($urandom_range(1, 4)) : k_mode;
        start_cnt <= start_cnt + 1;
        log_a.push_back(mm_a);
        log_b.push_back(mm_b);
      end
      if (spur_tog != spur_seen) begin
        spur_seen <= spur_tog;
        mm_done   <= 1'b1;
        mm_result <= rnd_w();
      end
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic load(input logic [W-1:0] m, input logic [W-1:0] x,
                      input logic [EW-1:0] e, input logic [LW-1:0] elen);
    in_m    = m;
    in_xm   = to_mont(x, m);
    in_rm   = to_mont(W'(1), m);
    in_e    = e;
    in_elen = elen;
  endtask

  task automatic wait_done(input int base_d, output logic ok);
    ok = 1'b0;
    for (int c = 0; c < 30000; c++) begin
      if (done_cnt != base_d) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic run_op(input string name, input logic [W-1:0] m, input logic [W-1:0] x,
                        input logic [EW-1:0] e, input logic [LW-1:0] elen, input int k,
                        input logic [W-1:0] exp_res, input int exp_pulses);
    int base_s, base_d, base_st;
    logic ok;
    logic [W-1:0] rm;
    @(negedge clk);
    k_mode = k;
    load(m, x, e, elen);
    rm      = in_rm;
    base_s  = start_cnt;
    base_d  = done_cnt;
    base_st = stab_cnt;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({name, "_busy"}, W'(busy), W'(1));
    wait_done(base_d, ok);
    chk({name, "_timeout"}, W'(ok), W'(1));
    chk({name, "_result"}, result, exp_res);
    repeat (5) @(negedge clk);
    chk({name, "_pulses"}, W'(start_cnt - base_s), W'(exp_pulses));
    chk({name, "_dones"}, W'(done_cnt - base_d), W'(1));
    chk({name, "_stable"}, W'(stab_cnt - base_st), W'(0));
    chk({name, "_idle"}, W'(busy), W'(0));
    if (start_cnt > base_s) begin
      chk({name, "_first_a"}, log_a[base_s], rm);
      chk({name, "_first_b"}, log_b[base_s], (elen == '0) ? W'(1) : rm);
    end
  endtask

  typedef struct {
    string         name;
    logic [W-1:0]  m;
    logic [W-1:0]  x;
    logic [EW-1:0] e;
    logic [LW-1:0] elen;
    int            k;
    logic [W-1:0]  exp_res;
    int            exp_pulses;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic ok;
    int base_s, base_d;
    logic [W-1:0] rm6, x6, e6, res_hold, one, mask;

    vecs[0] = '{"v_b3_e11",   W'(241), W'(3),   EW'(11),    LW'(4),   1, W'(12),  8};
    vecs[1] = '{"v_elen0",    W'(241), W'(3),   EW'(255),   LW'(0),   7, W'(1),   1};
    vecs[2] = '{"v_e0_l8",    W'(241), W'(3),   EW'(0),     LW'(8),   1, W'(1),   9};
    vecs[3] = '{"v_b5_e3",    W'(241), W'(5),   EW'(3),     LW'(2),   7, W'(125), 5};
    vecs[4] = '{"v_highbits", W'(241), W'(3),   EW'(3851),  LW'(4),   0, W'(12),  8};
    vecs[5] = '{"v_m13",      W'(13),  W'(2),   EW'(10),    LW'(4),   0, W'(10),  7};
    vecs[6] = '{"v_elen1",    W'(241), W'(200), EW'(1),     LW'(1),   1, W'(200), 3};
    vecs[7] = '{"v_elen_sat", W'(241), W'(7),   EW'(1),     LW'(600), 1, W'(7),   514};

    resetn = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_result", result, '0);
    chk("rst_done", W'(done), '0);
    chk("rst_busy", W'(busy), '0);
    chk("rst_mm_start", W'(mm_start), '0);
    chk("rst_mm_a", mm_a, '0);
    chk("rst_mm_b", mm_b, '0);
    chk("rst_mm_m", mm_m, '0);
    resetn = 1'b1;
    @(negedge clk);

    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].m, vecs[i].x, vecs[i].e, vecs[i].elen, vecs[i].k,
             vecs[i].exp_res, vecs[i].exp_pulses);

    // start during MUL_WAIT and during the done cycle must be ignored
    @(negedge clk);
    k_mode = 7;
    load(W'(241), W'(3), EW'(11), LW'(4));
    base_s = start_cnt;
    base_d = done_cnt;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (start_cnt - base_s == 2) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("ign_reach_mul", W'(ok), W'(1));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 500; c++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("ign_reach_done", W'(ok), W'(1));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    chk("ign_pulses", W'(start_cnt - base_s), W'(8));
    chk("ign_dones", W'(done_cnt - base_d), W'(1));
    chk("ign_result", result, W'(12));
    chk("ign_idle", W'(busy), '0);

    // spurious mm_done while idle
    base_s = start_cnt;
    base_d = done_cnt;
    spur_tog = ~spur_tog;
    repeat (6) @(negedge clk);
    chk("spur_busy", W'(busy), '0);
    chk("spur_pulses", W'(start_cnt - base_s), '0);
    chk("spur_dones", W'(done_cnt - base_d), '0);
    chk("spur_result", result, W'(12));

    // reset for one cycle while in SQ_WAIT
    k_mode = 7;
    load(W'(241), W'(3), EW'(11), LW'(4));
    base_s = start_cnt;
    base_d = done_cnt;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (start_cnt - base_s == 1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("rstmid_reach_sq", W'(ok), W'(1));
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    chk("rstmid_busy", W'(busy), '0);
    chk("rstmid_mm_start", W'(mm_start), '0);
    chk("rstmid_result", result, '0);
    chk("rstmid_mm_a", mm_a, '0);
    repeat (20) @(negedge clk);
    chk("rstmid_no_done", W'(done_cnt - base_d), '0);
    chk("rstmid_no_start", W'(start_cnt - base_s), W'(1));
    run_op("rstmid_rerun", W'(241), W'(3), EW'(11), LW'(4), 1, W'(12), 8);

    // full-width random exponentiations against a plain modexp
    one = W'(1);
    for (int t = 0; t < 2; t++) begin
      int n;
      n    = (t == 0) ? 512 : 100;
      rm6  = rnd_w() | one | (one << (W - 1));
      x6   = rnd_w() % rm6;
      e6   = rnd_w();
      mask = (n == 512) ? '1 : ((one << n) - one);
      res_hold = modexp(x6, e6, n, rm6);
      run_op((t == 0) ? "rand_full" : "rand_l100", rm6, x6, e6, LW'(n), 0, res_hold,
             n + $countones(e6 & mask) + 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
